// File: rtl/nes_input_reader.sv
// NES gamepad serial front end: latch/pulse generator, 8-bit deserialiser,
// per-frame held button state and one-cycle press pulses.
module nes_input_reader #(
  parameter int HALF_CYCLES = 300,
  parameter int POLL_CYCLES = 833333
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       nes_data,
  output logic       nes_latch,
  output logic       nes_pulse,
  output logic [7:0] buttons,
  output logic [7:0] pressed,
  output logic       forward,
  output logic       backward,
  output logic       frame_done
);

  localparam int PW = (POLL_CYCLES > 1) ? $clog2(POLL_CYCLES) : 1;
  localparam int TW = $clog2(2 * HALF_CYCLES + 1);

  localparam logic [PW-1:0] POLL_LAST  = PW'(POLL_CYCLES - 1);
  localparam logic [TW-1:0] LATCH_LAST = TW'(2 * HALF_CYCLES - 1);
  localparam logic [TW-1:0] HALF_LAST  = TW'(HALF_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    LATCH,
    PLO,
    PHI,
    DONE
  } state_t;

  state_t state;
  state_t state_n;

  logic [PW-1:0] poll_cnt;
  logic          poll_wrap;
  logic [TW-1:0] timer;
  logic [TW-1:0] timer_n;
  logic [3:0]    bit_cnt;
  logic [3:0]    bit_cnt_n;
  logic [7:0]    shreg;
  logic          sample;

  assign poll_wrap = (poll_cnt == POLL_LAST);

  // Free-running frame timebase, independent of the FSM
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      poll_cnt <= '0;
    end else if (poll_wrap) begin
      poll_cnt <= '0;
    end else begin
      poll_cnt <= poll_cnt + 1'b1;
    end
  end

  always_comb begin
    state_n   = state;
    timer_n   = timer + 1'b1;
    bit_cnt_n = bit_cnt;
    sample    = 1'b0;
    unique case (state)
      IDLE: begin
        timer_n = '0;
        if (poll_wrap) begin
          state_n = LATCH;
        end
      end
      LATCH: begin
        if (timer == LATCH_LAST) begin
          sample    = 1'b1;
          bit_cnt_n = 4'd1;
          timer_n   = '0;
          state_n   = PLO;
        end
      end
      PLO: begin
        if (timer == HALF_LAST) begin
          timer_n = '0;
          state_n = (bit_cnt == 4'd8) ? DONE : PHI;
        end
      end
      PHI: begin
        if (timer == HALF_LAST) begin
          sample    = 1'b1;
          bit_cnt_n = bit_cnt + 1'b1;
          timer_n   = '0;
          state_n   = PLO;
        end
      end
      DONE: begin
        timer_n = '0;
        state_n = IDLE;
      end
      default: begin
        timer_n = '0;
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      timer   <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
    end else begin
      state   <= state_n;
      timer   <= timer_n;
      bit_cnt <= bit_cnt_n;
      if (sample) begin
        shreg <= {shreg[6:0], ~nes_data};
      end
    end
  end

  // Strobes follow the next state so they line up with state entry
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      nes_latch <= 1'b0;
      nes_pulse <= 1'b0;
    end else begin
      nes_latch <= (state_n == LATCH);
      nes_pulse <= (state_n == PHI);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      buttons    <= '0;
      pressed    <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= (state == DONE);
      if (state == DONE) begin
        buttons <= shreg;
        pressed <= shreg & ~buttons;
      end else begin
        pressed <= '0;
      end
    end
  end

  assign forward  = pressed[4];
  assign backward = pressed[5];

endmodule

// File: tb/tb_nes_input_reader.sv
// Directed bench for nes_input_reader with a serial controller model
// and a per-frame scoreboard of expected buttons/pressed values.
module tb_nes_input_reader;

  logic       clk;
  logic       reset;
  logic       nes_data;
  logic       nes_latch;
  logic       nes_pulse;
  logic [7:0] buttons;
  logic [7:0] pressed;
  logic       forward;
  logic       backward;
  logic       frame_done;

  int comps = 0;
  int errs  = 0;

  logic [7:0]  pad  = 8'h00;
  logic [7:0]  prev = 8'h00;
  int          k    = 8;
  logic [15:0] q[$];

  nes_input_reader #(
    .HALF_CYCLES(2),
    .POLL_CYCLES(40)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .nes_data  (nes_data),
    .nes_latch (nes_latch),
    .nes_pulse (nes_pulse),
    .buttons   (buttons),
    .pressed   (pressed),
    .forward   (forward),
    .backward  (backward),
    .frame_done(frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Controller: bit k is presented after the k-th pulse rising edge
  always @(posedge nes_latch) k = 0;
  always @(posedge nes_pulse) k = k + 1;
  assign nes_data = (k < 8) ? ~pad[7-k] : 1'b1;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    comps++;
    assert (got === exp)
    else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Scoreboard consumer
  always @(negedge clk) begin
    if (!reset) begin
      if (frame_done) begin
        if (q.size() == 0) begin
          check("unexpected_frame", 32'd1, 32'd0);
        end else begin
          logic [15:0] e;
          e = q.pop_front();
          check("buttons", {24'd0, buttons}, {24'd0, e[15:8]});
          check("pressed", {24'd0, pressed}, {24'd0, e[7:0]});
          check("fwd_bwd", {30'd0, forward, backward},
                {30'd0, e[4], e[5]});
        end
      end else begin
        check("pressed_idle", {22'd0, pressed, forward, backward}, 32'd0);
      end
    end
  end

  task automatic push_exp(input logic [7:0] p);
    q.push_back({p, p & ~prev});
    prev = p;
  endtask

  task automatic wait_frame();
    bit got;
    got = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      #1;
      if (frame_done) begin
        got = 1'b1;
        break;
      end
    end
    check("frame_timeout", {31'd0, got}, 32'd1);
  endtask

  task automatic run_frame(input logic [7:0] p);
    pad = p;
    push_exp(p);
    wait_frame();
  endtask

  task automatic latch_delay(input string tag);
    int n;
    n = 0;
    for (int i = 1; i <= 100; i++) begin
      @(posedge clk);
      #1;
      if (nes_latch) begin
        n = i;
        break;
      end
    end
    check(tag, n, 40);
  endtask

  initial begin
    int   lat_hi;
    int   rises;
    int   phi_cyc;
    int   overlap;
    int   fd_at;
    logic pp;
    bit   seen;

    reset = 1'b1;
    pad   = 8'h00;
    push_exp(8'h00);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    check("rst_outs", {13'd0, nes_latch, nes_pulse, buttons, pressed,
                       frame_done}, 32'd0);

    // Frame waveform with no buttons
    latch_delay("first_latch");
    lat_hi  = 1;
    rises   = 0;
    phi_cyc = 0;
    overlap = 0;
    fd_at   = -1;
    pp      = nes_pulse;
    for (int c = 1; c <= 60; c++) begin
      @(posedge clk);
      #1;
      if (nes_latch) lat_hi++;
      if (nes_pulse) phi_cyc++;
      if (nes_pulse && !pp) rises++;
      if (nes_latch && nes_pulse) overlap++;
      pp = nes_pulse;
      if (frame_done) begin
        fd_at = c;
        break;
      end
    end
    check("latch_high", lat_hi, 4);
    check("pulse_rises", rises, 7);
    check("pulse_high", phi_cyc, 14);
    check("latch_pulse_overlap", overlap, 0);
    check("frame_len", fd_at, 35);
    check("idle_buttons", {24'd0, buttons}, 32'd0);

    // Start held three frames
    run_frame(8'h10);
    run_frame(8'h10);
    run_frame(8'h10);
    run_frame(8'h00);

    // Select re-press
    run_frame(8'h20);
    run_frame(8'h00);
    run_frame(8'h20);
    run_frame(8'h00);

    // Bit order: A, Up, Right
    run_frame(8'h89);
    run_frame(8'h89);
    run_frame(8'h00);

    // Start+Select together
    run_frame(8'h30);

    // Reset mid-PHI discards the frame
    pad  = 8'hff;
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      #1;
      if (nes_pulse) begin
        seen = 1'b1;
        break;
      end
    end
    check("reach_phi", {31'd0, seen}, 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check("midrst_strobes", {30'd0, nes_latch, nes_pulse}, 32'd0);
    check("midrst_buttons", {24'd0, buttons}, 32'd0);
    check("midrst_pulses", {22'd0, pressed, frame_done, forward | backward},
          32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    prev  = 8'h00;
    push_exp(8'hff);
    latch_delay("relatch_delay");
    wait_frame();

    repeat (2) @(negedge clk);
    check("queue_empty", q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", comps, errs);
    $finish;
  end

endmodule
